// File: rtl/menu_config_multicampo.sv
// Multi-field configuration menu: one FSM walks NUM_CAMPOS fields with
// wrapping arrows, auto-repeat, enter to commit and back to revisit.
module menu_config_multicampo #(
  parameter int                          NUM_CAMPOS    = 4,
  parameter int                          CAMPO_W       = 2,
  parameter int                          OPT_W         = 4,
  parameter logic [NUM_CAMPOS*OPT_W-1:0] MAX_IDX       = 16'hF313,
  parameter int                          HOLD_CYCLES   = 25000000,
  parameter int                          REPEAT_CYCLES = 5000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          inicia_menu,
  input  logic                          right_arrow_pressed,
  input  logic                          left_arrow_pressed,
  input  logic                          enter_pressed,
  input  logic                          back_pressed,
  output logic                          menu_ativo,
  output logic [CAMPO_W-1:0]            campo,
  output logic [OPT_W-1:0]              opcao,
  // "config" is a reserved word in SystemVerilog, so the committed bus is config_bus
  output logic [NUM_CAMPOS*OPT_W-1:0]   config_bus,
  output logic [NUM_CAMPOS-1:0]         registra,
  output logic                          fim_menu,
  output logic [2:0]                    db_estado
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] NAVEGA = 3'd1;
  localparam logic [2:0] COMMIT = 3'd2;
  localparam logic [2:0] FIM    = 3'd3;

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_ULT   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_SAT   = HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]   REP_ULT    = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [CAMPO_W-1:0] CAMPO_ULT  = CAMPO_W'(NUM_CAMPOS - 1);

  logic [2:0]         estado;
  logic               prev_dir, prev_esq, prev_ent, prev_vol;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [REP_W-1:0]   rep_cnt;

  logic               press_dir, press_esq, press_ent, press_vol;
  logic               seta_unica, passo;
  logic [OPT_W-1:0]   max_atual;

  function automatic logic [OPT_W-1:0] le_campo(
    input logic [NUM_CAMPOS*OPT_W-1:0] vet,
    input logic [CAMPO_W-1:0]          c
  );
    return vet[c*OPT_W +: OPT_W];
  endfunction

  function automatic logic [OPT_W-1:0] passo_dir(
    input logic [OPT_W-1:0] op,
    input logic [OPT_W-1:0] mx
  );
    return (op == mx) ? '0 : op + 1'b1;
  endfunction

  function automatic logic [OPT_W-1:0] passo_esq(
    input logic [OPT_W-1:0] op,
    input logic [OPT_W-1:0] mx
  );
    return (op == '0) ? mx : op - 1'b1;
  endfunction

  always_comb begin
    press_dir  = right_arrow_pressed & ~prev_dir;
    press_esq  = left_arrow_pressed  & ~prev_esq;
    press_ent  = enter_pressed       & ~prev_ent;
    press_vol  = back_pressed        & ~prev_vol;
    seta_unica = right_arrow_pressed ^ left_arrow_pressed;
    max_atual  = MAX_IDX[campo*OPT_W +: OPT_W];
    // hold_cnt saturates at HOLD_SAT once the first repeat has fired
    passo      = seta_unica &&
                 (press_dir || press_esq || (hold_cnt == HOLD_ULT) ||
                  ((hold_cnt == HOLD_SAT) && (rep_cnt == REP_ULT)));
  end

  assign menu_ativo = (estado == NAVEGA);
  assign db_estado  = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= IDLE;
      campo      <= '0;
      opcao      <= '0;
      config_bus <= '0;
      registra   <= '0;
      fim_menu   <= 1'b0;
      prev_dir   <= 1'b0;
      prev_esq   <= 1'b0;
      prev_ent   <= 1'b0;
      prev_vol   <= 1'b0;
      hold_cnt   <= '0;
      rep_cnt    <= '0;
    end else begin
      prev_dir <= right_arrow_pressed;
      prev_esq <= left_arrow_pressed;
      prev_ent <= enter_pressed;
      prev_vol <= back_pressed;
      registra <= '0;
      fim_menu <= 1'b0;
      hold_cnt <= '0;
      rep_cnt  <= '0;

      case (estado)
        IDLE, FIM: begin
          if (inicia_menu) begin
            estado <= NAVEGA;
            campo  <= '0;
            opcao  <= le_campo(config_bus, '0);
          end
        end

        NAVEGA: begin
          if (inicia_menu) begin
            campo <= '0;
            opcao <= le_campo(config_bus, '0);
          end else if (press_ent) begin
            estado   <= COMMIT;
            registra <= NUM_CAMPOS'(1) << campo;
          end else if (press_vol) begin
            if (campo != '0) begin
              campo <= campo - 1'b1;
              opcao <= le_campo(config_bus, campo - 1'b1);
            end else begin
              estado <= IDLE;
            end
          end else if (seta_unica) begin
            if (passo)
              opcao <= right_arrow_pressed ? passo_dir(opcao, max_atual)
                                           : passo_esq(opcao, max_atual);
            if (press_dir || press_esq) begin
              hold_cnt <= HOLD_W'(1);
            end else if (hold_cnt != HOLD_SAT) begin
              hold_cnt <= hold_cnt + 1'b1;
            end else begin
              hold_cnt <= hold_cnt;
              rep_cnt  <= (rep_cnt == REP_ULT) ? '0 : rep_cnt + 1'b1;
            end
          end
        end

        COMMIT: begin
          config_bus[campo*OPT_W +: OPT_W] <= opcao;
          if (campo == CAMPO_ULT) begin
            estado   <= FIM;
            fim_menu <= 1'b1;
          end else begin
            estado <= NAVEGA;
            campo  <= campo + 1'b1;
            opcao  <= le_campo(config_bus, campo + 1'b1);
          end
        end

        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_menu_config_multicampo.sv
// Directed bench for menu_config_multicampo: one-cycle vector table plus
// hand-written hold/auto-repeat and reset sequences.
module tb_menu_config_multicampo;

  logic        clock = 1'b0;
  logic        reset;
  logic        inicia_menu, right_arrow_pressed, left_arrow_pressed;
  logic        enter_pressed, back_pressed;
  logic        menu_ativo;
  logic [1:0]  campo;
  logic [3:0]  opcao;
  logic [15:0] config_bus;
  logic [3:0]  registra;
  logic        fim_menu;
  logic [2:0]  db_estado;

  int n_vec = 0;
  int n_err = 0;

  menu_config_multicampo #(
    .NUM_CAMPOS(4), .CAMPO_W(2), .OPT_W(4), .MAX_IDX(16'hF313),
    .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset), .inicia_menu(inicia_menu),
    .right_arrow_pressed(right_arrow_pressed), .left_arrow_pressed(left_arrow_pressed),
    .enter_pressed(enter_pressed), .back_pressed(back_pressed),
    .menu_ativo(menu_ativo), .campo(campo), .opcao(opcao), .config_bus(config_bus),
    .registra(registra), .fim_menu(fim_menu), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // key vector bit order: {inicia, right, left, enter, back}
  localparam logic [4:0] K_N = 5'b00000;
  localparam logic [4:0] K_I = 5'b10000;
  localparam logic [4:0] K_R = 5'b01000;
  localparam logic [4:0] K_L = 5'b00100;
  localparam logic [4:0] K_E = 5'b00010;
  localparam logic [4:0] K_B = 5'b00001;

  typedef struct {
    string       nome;
    logic [4:0]  teclas;
    logic [2:0]  est;
    logic [1:0]  cmp;
    logic [3:0]  op;
    logic [15:0] cfg;
    logic [3:0]  regi;
    logic        fim;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic [4:0] k, input logic [2:0] e,
                              input logic [1:0] c, input logic [3:0] o, input logic [15:0] cf,
                              input logic [3:0] r, input logic f);
    vec_t v;
    v.nome = n; v.teclas = k; v.est = e; v.cmp = c; v.op = o;
    v.cfg = cf; v.regi = r; v.fim = f;
    return v;
  endfunction

  task automatic add(input string n, input logic [4:0] k, input logic [2:0] e,
                     input logic [1:0] c, input logic [3:0] o, input logic [15:0] cf,
                     input logic [3:0] r, input logic f);
    tbl.push_back(mk(n, k, e, c, o, cf, r, f));
  endtask

  task automatic apply(input logic [4:0] k);
    {inicia_menu, right_arrow_pressed, left_arrow_pressed, enter_pressed, back_pressed} = k;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input vec_t v);
    logic exp_ativo;
    exp_ativo = (v.est == 3'd1);
    n_vec++;
    if (db_estado !== v.est || campo !== v.cmp || opcao !== v.op || config_bus !== v.cfg ||
        registra !== v.regi || fim_menu !== v.fim || menu_ativo !== exp_ativo) begin
      n_err++;
      $display("FAIL %s: got estado=%0d campo=%0d opcao=%0d config=%h registra=%b fim=%b ativo=%b, want estado=%0d campo=%0d opcao=%0d config=%h registra=%b fim=%b ativo=%b",
               v.nome, db_estado, campo, opcao, config_bus, registra, fim_menu, menu_ativo,
               v.est, v.cmp, v.op, v.cfg, v.regi, v.fim, exp_ativo);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_hold [20];
    exp_hold = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2,
                 4'd3, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd6};

    //   name           keys       est  cmp op     cfg       reg      fim
    add("idle_quiet",   K_N,       0,   0,  0,  16'h0000, 4'b0000, 0);
    add("idle_key_ign", K_R,       0,   0,  0,  16'h0000, 4'b0000, 0);
    add("idle_rel",     K_N,       0,   0,  0,  16'h0000, 4'b0000, 0);
    add("start",        K_I,       1,   0,  0,  16'h0000, 4'b0000, 0);
    add("f0_r1",        K_R,       1,   0,  1,  16'h0000, 4'b0000, 0);
    add("f0_rel1",      K_N,       1,   0,  1,  16'h0000, 4'b0000, 0);
    add("f0_r2",        K_R,       1,   0,  2,  16'h0000, 4'b0000, 0);
    add("f0_rel2",      K_N,       1,   0,  2,  16'h0000, 4'b0000, 0);
    add("f0_r3",        K_R,       1,   0,  3,  16'h0000, 4'b0000, 0);
    add("f0_rel3",      K_N,       1,   0,  3,  16'h0000, 4'b0000, 0);
    add("f0_r_wrap",    K_R,       1,   0,  0,  16'h0000, 4'b0000, 0);
    add("f0_rel4",      K_N,       1,   0,  0,  16'h0000, 4'b0000, 0);
    add("f0_r5",        K_R,       1,   0,  1,  16'h0000, 4'b0000, 0);
    add("f0_rel5",      K_N,       1,   0,  1,  16'h0000, 4'b0000, 0);
    add("f0_commit",    K_E,       2,   0,  1,  16'h0000, 4'b0001, 0);
    add("f1_enter",     K_N,       1,   1,  0,  16'h0001, 4'b0000, 0);
    add("f1_l_wrap",    K_L,       1,   1,  1,  16'h0001, 4'b0000, 0);
    add("f1_rel",       K_N,       1,   1,  1,  16'h0001, 4'b0000, 0);
    add("f1_rl_ign",    K_R | K_L, 1,   1,  1,  16'h0001, 4'b0000, 0);
    add("f1_rel2",      K_N,       1,   1,  1,  16'h0001, 4'b0000, 0);
    add("f1_r_wrap",    K_R,       1,   1,  0,  16'h0001, 4'b0000, 0);
    add("f1_rel3",      K_N,       1,   1,  0,  16'h0001, 4'b0000, 0);
    add("f1_r",         K_R,       1,   1,  1,  16'h0001, 4'b0000, 0);
    add("f1_rel4",      K_N,       1,   1,  1,  16'h0001, 4'b0000, 0);
    add("f1_commit",    K_E,       2,   1,  1,  16'h0001, 4'b0010, 0);
    add("f2_enter",     K_N,       1,   2,  0,  16'h0011, 4'b0000, 0);
    add("f2_l_wrap",    K_L,       1,   2,  3,  16'h0011, 4'b0000, 0);
    add("f2_rel",       K_N,       1,   2,  3,  16'h0011, 4'b0000, 0);
    add("f2_commit",    K_E,       2,   2,  3,  16'h0011, 4'b0100, 0);
    add("f3_enter",     K_N,       1,   3,  0,  16'h0311, 4'b0000, 0);
    add("f3_l_wrap",    K_L,       1,   3, 15,  16'h0311, 4'b0000, 0);
    add("f3_rel",       K_N,       1,   3, 15,  16'h0311, 4'b0000, 0);
    add("f3_commit",    K_E,       2,   3, 15,  16'h0311, 4'b1000, 0);
    add("fim_pulse",    K_N,       3,   3, 15,  16'hF311, 4'b0000, 1);
    add("fim_hold",     K_N,       3,   3, 15,  16'hF311, 4'b0000, 0);
    add("fim_key_ign",  K_R,       3,   3, 15,  16'hF311, 4'b0000, 0);
    add("fim_rel",      K_N,       3,   3, 15,  16'hF311, 4'b0000, 0);
    add("restart",      K_I,       1,   0,  1,  16'hF311, 4'b0000, 0);
    add("r0_r",         K_R,       1,   0,  2,  16'hF311, 4'b0000, 0);
    add("r0_rel",       K_N,       1,   0,  2,  16'hF311, 4'b0000, 0);
    add("r0_commit",    K_E,       2,   0,  2,  16'hF311, 4'b0001, 0);
    add("r1_enter",     K_N,       1,   1,  1,  16'hF312, 4'b0000, 0);
    add("back_to_f0",   K_B,       1,   0,  2,  16'hF312, 4'b0000, 0);
    add("back_rel",     K_N,       1,   0,  2,  16'hF312, 4'b0000, 0);
    add("back_to_idle", K_B,       0,   0,  2,  16'hF312, 4'b0000, 0);
    add("idle_kept",    K_N,       0,   0,  2,  16'hF312, 4'b0000, 0);
    add("restart2",     K_I,       1,   0,  2,  16'hF312, 4'b0000, 0);
    add("enter_vs_back",K_E | K_B, 2,   0,  2,  16'hF312, 4'b0001, 0);
    add("s1_enter",     K_N,       1,   1,  1,  16'hF312, 4'b0000, 0);
    add("s1_commit",    K_E,       2,   1,  1,  16'hF312, 4'b0010, 0);
    add("s2_enter",     K_N,       1,   2,  3,  16'hF312, 4'b0000, 0);
    add("s2_commit",    K_E,       2,   2,  3,  16'hF312, 4'b0100, 0);
    add("s3_enter",     K_N,       1,   3, 15,  16'hF312, 4'b0000, 0);
    add("s3_r_wrap",    K_R,       1,   3,  0,  16'hF312, 4'b0000, 0);
    add("s3_rel",       K_N,       1,   3,  0,  16'hF312, 4'b0000, 0);

    reset = 1'b1;
    apply(K_N);
    apply(K_N);
    check(mk("reset_state", K_N, 0, 0, 0, 16'h0000, 4'b0000, 0));
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].teclas);
      check(tbl[i]);
    end

    // held right arrow in field 3: step on press, at +7, then every 3 cycles
    for (int k = 0; k < 20; k++) begin
      apply(K_R);
      check(mk($sformatf("hold_c%0d", k), K_R, 1, 3, exp_hold[k], 16'hF312, 4'b0000, 0));
    end
    apply(K_N);
    check(mk("hold_release", K_N, 1, 3, 6, 16'hF312, 4'b0000, 0));

    // counters must restart from zero after the release
    for (int k = 0; k < 8; k++) begin
      apply(K_R);
      check(mk($sformatf("rehold_c%0d", k), K_R, 1, 3, (k < 7) ? 4'd7 : 4'd8,
               16'hF312, 4'b0000, 0));
    end
    apply(K_N);
    check(mk("rehold_release", K_N, 1, 3, 8, 16'hF312, 4'b0000, 0));

    // inicia_menu while navigating returns to field 0
    apply(K_I);
    check(mk("reinicia_nav", K_I, 1, 0, 2, 16'hF312, 4'b0000, 0));
    apply(K_N);
    check(mk("reinicia_rel", K_N, 1, 0, 2, 16'hF312, 4'b0000, 0));

    // reset mid-navigation clears everything including stored choices
    reset = 1'b1;
    apply(K_N);
    check(mk("reset_mid_nav", K_N, 0, 0, 0, 16'h0000, 4'b0000, 0));
    reset = 1'b0;
    apply(K_N);
    check(mk("post_reset_idle", K_N, 0, 0, 0, 16'h0000, 4'b0000, 0));
    apply(K_I);
    check(mk("post_reset_start", K_I, 1, 0, 0, 16'h0000, 4'b0000, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
